// File: rtl/alu.sv
// Nibble ALU slice: add/logic/shift on 4-bit operands, one registered output stage.
// Carry chains between nibbles through carry_in/carry_out under sequencer control.
module alu (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] cmd,
    input  logic       carry_in,
    input  logic       carry_disable,
    input  logic       b_inv,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    output logic       out_valid,
    output logic [3:0] res,
    output logic       carry_out,
    output logic       zero
);

    typedef enum logic [2:0] {
        CMD_ADD   = 3'd0,
        CMD_AND   = 3'd1,
        CMD_OR    = 3'd2,
        CMD_XOR   = 3'd3,
        CMD_LSHFT = 3'd4,
        CMD_RSHFT = 3'd5
    } cmd_e;

    logic [3:0] b;
    logic       c;
    logic [4:0] sum;
    logic [3:0] res_d, res_q;
    logic       carry_d, carry_q;
    logic       valid_q, zero_q;

    assign b   = b_inv ? ~d2 : d2;
    assign c   = carry_disable ? 1'b0 : carry_in;
    assign sum = {1'b0, d1} + {1'b0, b} + {4'b0, c};

    always_comb begin
        res_d   = 4'h0;
        carry_d = 1'b0;
        case (cmd)
            CMD_ADD:   {carry_d, res_d} = sum;
            CMD_AND:   res_d = d1 & b;
            CMD_OR:    res_d = d1 | b;
            CMD_XOR:   res_d = d1 ^ b;
            CMD_LSHFT: begin
                res_d   = {b[2:0], c};
                carry_d = b[3];
            end
            CMD_RSHFT: begin
                res_d   = {c, b[3:1]};
                carry_d = b[0];
            end
            // Reserved codes yield a zero result but still report valid.
            default: begin
                res_d   = 4'h0;
                carry_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= 4'h0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                res_q   <= res_d;
                carry_q <= carry_d;
                zero_q  <= (res_d == 4'h0);
            end
        end
    end

    assign out_valid = valid_q;
    assign res       = res_q;
    assign carry_out = carry_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed plus randomized bench for the nibble ALU slice against an arithmetic model.
module tb_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] cmd;
    logic       carry_in;
    logic       carry_disable;
    logic       b_inv;
    logic [3:0] d1;
    logic [3:0] d2;
    logic       out_valid;
    logic [3:0] res;
    logic       carry_out;
    logic       zero;

    int n_assert = 0;
    int n_fail   = 0;

    logic       e_v;
    logic [3:0] e_res;
    logic       e_co;
    logic       e_zero;

    always #5 clk = ~clk;

    alu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .cmd(cmd),
        .carry_in(carry_in), .carry_disable(carry_disable), .b_inv(b_inv),
        .d1(d1), .d2(d2), .out_valid(out_valid), .res(res),
        .carry_out(carry_out), .zero(zero)
    );

    // Returns {carry, result} from integer arithmetic on the operation rules.
    function automatic logic [4:0] model(input int op, input int ci, input int cd,
                                         input int bi, input int a, input int d);
        int bb, cc, r, co;
        bb = bi ? (15 - d) : d;
        cc = cd ? 0 : ci;
        r = 0; co = 0;
        case (op)
            0: begin r = (a + bb + cc) % 16; co = (a + bb + cc) / 16; end
            1: r = a & bb;
            2: r = a | bb;
            3: r = a ^ bb;
            4: begin r = (bb * 2 + cc) % 16; co = bb / 8; end
            5: begin r = cc * 8 + bb / 2; co = bb % 2; end
            default: begin r = 0; co = 0; end
        endcase
        return {co[0], r[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".valid"}, {3'b0, out_valid}, {3'b0, e_v});
        chk({tag, ".res"},   res, e_res);
        chk({tag, ".carry"}, {3'b0, carry_out}, {3'b0, e_co});
        chk({tag, ".zero"},  {3'b0, zero}, {3'b0, e_zero});
    endtask

    task automatic set_reset_exp();
        e_v = 1'b0; e_res = 4'h0; e_co = 1'b0; e_zero = 1'b1;
    endtask

    task automatic step(input string tag, input logic v, input int op, input logic ci,
                        input logic cd, input logic bi, input logic [3:0] a,
                        input logic [3:0] d);
        logic [4:0] m;
        in_valid = v; cmd = op[2:0]; carry_in = ci; carry_disable = cd;
        b_inv = bi; d1 = a; d2 = d;
        if (v) begin
            m = model(op, int'(ci), int'(cd), int'(bi), int'(a), int'(d));
            e_v = 1'b1; e_co = m[4]; e_res = m[3:0]; e_zero = (m[3:0] == 4'h0);
        end else begin
            e_v = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; cmd = 0; carry_in = 0; carry_disable = 0;
        b_inv = 0; d1 = 0; d2 = 0;
        set_reset_exp();
        #12;
        chk_all("reset_init");
        rst = 1'b0;

        // Async reset while out_valid is high, no clock edge involved
        step("pre_rst", 1, 0, 0, 0, 0, 4'h1, 4'h2);
        #2 rst = 1'b1;
        #1;
        set_reset_exp();
        chk_all("async_rst");
        rst = 1'b0;

        step("add_4_4",      1, 0, 0, 0, 0, 4'h4, 4'h4);
        step("add_F_1",      1, 0, 0, 0, 0, 4'hF, 4'h1);
        step("add_E_0_c1",   1, 0, 1, 0, 0, 4'hE, 4'h0);
        step("add_cdis",     1, 0, 1, 1, 0, 4'hF, 4'h0);
        step("add_FF1",      1, 0, 1, 0, 0, 4'hF, 4'hF);
        step("inv_0_0",      1, 0, 0, 0, 1, 4'h0, 4'h0);
        step("sub_5_3",      1, 0, 1, 0, 1, 4'h5, 4'h3);
        step("rshft_6",      1, 5, 0, 0, 0, 4'h0, 4'h6);
        step("rshft_1_c1",   1, 5, 1, 0, 0, 4'h0, 4'h1);
        step("lshft_9",      1, 4, 0, 0, 0, 4'h0, 4'h9);
        step("and_CA",       1, 1, 1, 0, 0, 4'hC, 4'hA);
        step("or_CA",        1, 2, 1, 0, 0, 4'hC, 4'hA);
        step("xor_CA",       1, 3, 1, 0, 0, 4'hC, 4'hA);
        step("rsvd_7",       1, 7, 1, 0, 0, 4'h5, 4'h5);
        step("rsvd_6",       1, 6, 0, 0, 1, 4'h3, 4'h1);

        // Gap in in_valid: outputs hold, valid drops
        step("pre_gap",      1, 0, 0, 0, 0, 4'h3, 4'h4);
        step("gap",          0, 0, 0, 0, 0, 4'h9, 4'h9);
        step("post_gap",     1, 1, 0, 0, 0, 4'hF, 4'h6);

        // Inputs changing between edges must not disturb outputs
        d1 = 4'h0; d2 = 4'h0; cmd = 3'd2;
        #3;
        chk_all("mid_cycle");

        // Reset lands between operand setup and capture: result lost
        in_valid = 1; cmd = 0; d1 = 4'h7; d2 = 4'h7; carry_in = 0;
        carry_disable = 0; b_inv = 0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        set_reset_exp();
        chk_all("rst_midstream");
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                 4'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 4-bit (nibble) ALU slice with one registered output stage.
- Used by the nibble-loop sequencer, which processes a 32-bit word one nibble per cycle and chains carry between nibbles.
- Supports add with carry/invert for subtraction, bitwise logic, and 1-bit shifts through carry.
- Operands and control are captured on a valid strobe; the result is presented one clock later with a valid flag.

Parameters:
- none (datapath width fixed at 4 bits; command field fixed at 3 bits)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands/control valid this cycle
- cmd  in  3  0=ADD 1=AND 2=OR 3=XOR 4=LSHFT 5=RSHFT 6,7=reserved
- carry_in  in  1  carry/shift-in bit
- carry_disable  in  1  forces effective carry-in to 0
- b_inv  in  1  invert d2 before use
- d1  in  4  operand A
- d2  in  4  operand B / shift source
- out_valid  out  1  res/carry_out valid
- res  out  4  registered result nibble
- carry_out  out  1  registered carry / shifted-out bit
- zero  out  1  registered (res == 0)

Behaviour:
- Combinational pre-computation:
  - b = b_inv ? ~d2 : d2
  - c = carry_disable ? 0 : carry_in
- ADD: {carry_out, res} = d1 + b + c (5-bit sum). Subtraction is done by the sequencer via b_inv=1 with c=1 on the first nibble.
- AND / OR / XOR: res = d1 op b; carry_out = 0; c ignored.
- LSHFT: res = {b[2:0], c}; carry_out = b[3]; d1 ignored.
- RSHFT: res = {c, b[3:1]}; carry_out = b[0]; d1 ignored. The sequencer walks RSHFT from the MS nibble down, feeding each carry_out into the next nibble's carry_in.
- Reserved cmd 6/7: res = 0, carry_out = 0, zero = 1, out_valid still asserted.
- Pipeline timing:
  - On a clk rising edge with in_valid=1: res, carry_out, zero take the computed values and out_valid goes to 1.
  - On an edge with in_valid=0: out_valid goes to 0; res, carry_out, zero hold their previous values.
  - Latency is exactly 1 cycle. Throughput is 1 operation per cycle, with back-to-back in_valid allowed.
  - No backpressure: a result is valid only for the cycle following capture.
- Reset:
  - rst=1 immediately (no clock edge needed) forces out_valid=0, res=0, carry_out=0, zero=1.
  - Reset asserted mid-stream discards any captured result.
  - The first capture occurs on the first rising edge after rst deasserts with in_valid=1.
- Boundaries:
  - ADD with sum > 15: res wraps mod 16, carry_out=1.
  - ADD 0xF+0xF+1: res=0xF, carry_out=1.
  - Inputs are sampled only at the edge; changes between edges do not affect the outputs.

Test Plan:
- Reset: assert rst with out_valid=1 → out_valid=0, res=0, carry_out=0, zero=1 without a clock edge. Release rst, then ADD d1=4 d2=4 c=0 → next cycle res=8, carry_out=0, zero=0, out_valid=1.
- Carry chain:
  - ADD d1=0xF d2=1 c=0 → res=0, carry_out=1, zero=1.
  - Next cycle ADD d1=0xE d2=0 carry_in=1 → res=0xF, carry_out=0 (back-to-back, one result per cycle).
  - ADD d1=0xF d2=0 carry_in=1 carry_disable=1 → res=0xF, carry_out=0.
- Invert/subtract: ADD d1=0 d2=0 b_inv=1 c=0 → res=0xF, carry_out=0. ADD d1=5 d2=3 b_inv=1 c=1 → res=2, carry_out=1.
- Shifts:
  - RSHFT d2=6 c=0 → res=3, carry_out=0.
  - RSHFT d2=1 c=1 → res=8, carry_out=1.
  - LSHFT d2=0x9 c=0 → res=2, carry_out=1.
- Logic and reserved:
  - AND 0xC,0xA → 8; OR → 0xE; XOR → 6; each with carry_out=0 regardless of carry_in=1.
  - cmd=7 → res=0, zero=1, out_valid=1.
- Valid handling: drop in_valid for one cycle between ops → out_valid=0 that cycle with res holding the prior value. Assert rst between capture and output → result lost, out_valid=0.
